// File: rtl/shared_adder_sequencer_pkg.sv
// Shared constants and state encoding for the shared-slice adder sequencer.
package shared_adder_sequencer_pkg;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned SLICE_W = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/shared_adder_sequencer_add_slice2.sv
// Combinational 2-bit ripple adder slice: {cout, s} = a + b + cin.
module add_slice2
  import shared_adder_sequencer_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_s,
  output logic               o_cout
);

  always_comb begin
    {o_cout, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{SLICE_W{1'b0}}, i_cin};
  end

endmodule

// File: rtl/shared_adder_sequencer.sv
// Round-robin sequencer sharing one 2-bit adder slice between two requesters;
// a WIDTH-bit add takes WIDTH/2 slice cycles, LSB pair first.
module shared_adder_sequencer
  import shared_adder_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);

  localparam int unsigned STEPS = WIDTH / 2;
  localparam int unsigned CntW  = (STEPS > 1) ? $clog2(STEPS) : 1;

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("shared_adder_sequencer: WIDTH must be even and >= 2");
  end

  state_e            r_state, w_state_next;
  logic [WIDTH-1:0]  r_op_a, r_op_b, r_sum;
  logic              r_carry, r_id, r_last_grant;
  logic [CntW-1:0]   r_cnt;

  logic              w_pref, w_gnt_vld, w_gnt_id, w_accept, w_last_step;
  logic [SLICE_W-1:0] w_slice_s;
  logic              w_slice_cout;

  add_slice2 u_slice (
    .i_a    (r_op_a[SLICE_W-1:0]),
    .i_b    (r_op_b[SLICE_W-1:0]),
    .i_cin  (r_carry),
    .o_s    (w_slice_s),
    .o_cout (w_slice_cout)
  );

  // Requester after the last one served has priority.
  always_comb begin
    w_pref    = ~r_last_grant;
    w_gnt_vld = 1'b0;
    w_gnt_id  = w_pref;
    if (req_valid[w_pref]) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = w_pref;
    end else if (req_valid[~w_pref]) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = ~w_pref;
    end
  end

  assign w_accept    = |(req_valid & req_ready);
  assign w_last_step = (r_cnt == CntW'(STEPS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept)    w_state_next = StRun;
      StRun:   if (w_last_step) w_state_next = StDone;
      StDone:  if (rsp_ready)   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if ((r_state == StIdle) && !rst && w_gnt_vld) req_ready[w_gnt_id] = 1'b1;
    rsp_valid = (r_state == StDone);
    busy      = (r_state != StIdle);
    rsp_id    = r_id;
    rsp_sum   = r_sum;
    rsp_cout  = r_carry;
  end

  // Operands shift right past the slice; sum pairs shift in from the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_sum        <= '0;
      r_carry      <= 1'b0;
      r_id         <= 1'b0;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_op_a  <= w_gnt_id ? a1 : a0;
            r_op_b  <= w_gnt_id ? b1 : b0;
            r_carry <= w_gnt_id ? cin1 : cin0;
            r_id    <= w_gnt_id;
            r_cnt   <= '0;
          end
        end
        StRun: begin
          r_op_a  <= r_op_a >> SLICE_W;
          r_op_b  <= r_op_b >> SLICE_W;
          r_sum   <= (r_sum >> SLICE_W) | (WIDTH'(w_slice_s) << (WIDTH - SLICE_W));
          r_carry <= w_slice_cout;
          r_cnt   <= r_cnt + CntW'(1);
        end
        StDone: begin
          if (rsp_ready) r_last_grant <= r_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_adder_sequencer.sv
// Cycle-level bench: directed scenarios plus random traffic against a
// transaction-level reference (grant order, fixed latency, arithmetic sum).
module tb_shared_adder_sequencer;

  localparam int WIDTH = 8;
  localparam int STEPS = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid, req_ready;
  logic [WIDTH-1:0] a0, b0, a1, b1, rsp_sum;
  logic             cin0, cin1, rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;

  shared_adder_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a0        (a0),
    .b0        (b0),
    .cin0      (cin0),
    .a1        (a1),
    .b1        (b1),
    .cin1      (cin1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: phase 0 = waiting for a request, 1 = computing, 2 = result offered.
  int             m_phase;
  int             m_left;
  int             m_id;
  int             m_last;
  bit             m_fresh;  // no operation started since reset
  logic [WIDTH:0] m_full;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [1:0] v, input int last);
    int pref;
    pref = 1 - last;
    if (v[pref])     return pref;
    if (v[1 - pref]) return 1 - pref;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_left  = 0;
    m_id    = 0;
    m_last  = 1;
    m_fresh = 1'b1;
    m_full  = '0;
  endtask

  // Called at a falling edge with inputs already driven; ends at the next falling edge.
  task automatic step();
    int         g;
    logic [1:0] exp_rdy;
    #1;
    g = (m_phase == 0 && !rst) ? pick(req_valid, m_last) : -1;
    exp_rdy = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
    check_eq("busy", 32'(busy), 32'(m_phase != 0));
    if (m_phase == 2) begin
      check_eq("rsp_sum", 32'(rsp_sum), 32'(m_full[WIDTH-1:0]));
      check_eq("rsp_cout", 32'(rsp_cout), 32'(m_full[WIDTH]));
      check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
    end else if (m_fresh) begin
      check_eq("rst_sum", 32'(rsp_sum), 32'd0);
      check_eq("rst_cout", 32'(rsp_cout), 32'd0);
      check_eq("rst_id", 32'(rsp_id), 32'd0);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (g >= 0) begin
          m_phase = 1;
          m_left  = STEPS;
          m_id    = g;
          m_fresh = 1'b0;
          if (g == 0) m_full = {1'b0, a0} + {1'b0, b0} + (WIDTH+1)'(cin0);
          else        m_full = {1'b0, a1} + {1'b0, b1} + (WIDTH+1)'(cin1);
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (rsp_ready) begin
          m_phase = 0;
          m_last  = m_id;
        end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic rand_ops();
    a0   = WIDTH'($urandom);
    b0   = WIDTH'($urandom);
    cin0 = 1'($urandom);
    a1   = WIDTH'($urandom);
    b1   = WIDTH'($urandom);
    cin1 = 1'($urandom);
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    a0 = '0; b0 = '0; cin0 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    step();

    // 1: basic add from requester 0.
    rst = 1'b0;
    req_valid = 2'b01; a0 = 8'h5A; b0 = 8'h3C; cin0 = 1'b0;
    step();
    req_valid = 2'b00;
    repeat (STEPS) step();
    check_eq("t1_sum", 32'(rsp_sum), 32'h96);
    check_eq("t1_cout", 32'(rsp_cout), 32'd0);
    check_eq("t1_id", 32'(rsp_id), 32'd0);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

    // 2: carry-out wrap on both requesters.
    req_valid = 2'b01; a0 = 8'hFF; b0 = 8'h01; cin0 = 1'b0;
    step();
    req_valid = 2'b00;
    repeat (STEPS) step();
    check_eq("t2a_sum", 32'(rsp_sum), 32'h00);
    check_eq("t2a_cout", 32'(rsp_cout), 32'd1);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    req_valid = 2'b10; a1 = 8'hFF; b1 = 8'hFF; cin1 = 1'b1;
    step();
    req_valid = 2'b00;
    repeat (STEPS) step();
    check_eq("t2b_sum", 32'(rsp_sum), 32'hFF);
    check_eq("t2b_cout", 32'(rsp_cout), 32'd1);
    check_eq("t2b_id", 32'(rsp_id), 32'd1);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

    // 3: both requesting after reset alternate 0,1,0,1.
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int i = 0; i < 4 * (STEPS + 2); i++) begin
      rand_ops();
      step();
    end

    // 4: response held under back-pressure, then requester 1 granted.
    rsp_ready = 1'b0; req_valid = 2'b01; rand_ops();
    step();
    req_valid = 2'b10;
    repeat (STEPS + 3) step();
    rsp_ready = 1'b1;
    repeat (3) step();

    // 5: reset in the second computing cycle drops the operation.
    req_valid = 2'b00; rsp_ready = 1'b0;
    repeat (STEPS + 2) step();
    req_valid = 2'b10; rand_ops();
    step();
    req_valid = 2'b00;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_valid", 32'(rsp_valid), 32'd0);
    req_valid = 2'b11; rand_ops();
    step();
    req_valid = 2'b00; rsp_ready = 1'b1;
    repeat (STEPS + 2) step();

    // 6: lone requester 1 back-to-back.
    req_valid = 2'b10; rsp_ready = 1'b1;
    for (int i = 0; i < 3 * (STEPS + 2) + 1; i++) begin
      rand_ops();
      step();
    end

    // Random traffic with occasional reset and back-pressure.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
